// File: rtl/can_pkg.sv
// Shared types and constants for the CAN receive path: FSM states, error
// codes, CRC-15 polynomial and field widths.
package can_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ARB,
      CTRL,
      DATA,
      CRC,
      CRC_DEL,
      ACK,
      ACK_DEL,
      EOF
   } can_state_t;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_STUFF = 3'd1;
   localparam logic [2:0] ERR_FORM  = 3'd2;
   localparam logic [2:0] ERR_CRC   = 3'd3;
   localparam logic [2:0] ERR_IDE   = 3'd4;

   localparam logic [14:0] CRC15_POLY = 15'h4599;
   localparam int ID_W  = 11;
   localparam int DLC_W = 4;

   // One serial CRC-15 step for a single destuffed bit.
   function automatic logic [14:0] crc15_next(input logic [14:0] crc, input logic b);
      return {crc[13:0], 1'b0} ^ ((b ^ crc[14]) ? CRC15_POLY : 15'h0);
   endfunction

endpackage

// File: rtl/can_destuff.sv
// Bit destuffer: drops the bit after five equal bits and flags a stuff error
// when that bit does not toggle. init seeds the run with the SOF bit.
module can_destuff (
   input  logic can_clk,
   input  logic reset,
   input  logic bit_en,
   input  logic bit_in,
   input  logic init,
   input  logic enable,
   output logic dbit,
   output logic dvalid,
   output logic stuff_err
);

   logic       run_bit;
   logic [2:0] run_len;
   logic       is_stuff;

   assign is_stuff  = (run_len == 3'd5);
   assign dbit      = bit_in;
   assign dvalid    = bit_en & enable & ~is_stuff;
   assign stuff_err = bit_en & enable & is_stuff & (bit_in == run_bit);

   // A discarded stuff bit starts a fresh run of length one.
   always_ff @(posedge can_clk or posedge reset) begin
      if (reset) begin
         run_bit <= 1'b1;
         run_len <= 3'd0;
      end else if (bit_en) begin
         if (init) begin
            run_bit <= bit_in;
            run_len <= 3'd1;
         end else if (enable) begin
            if (is_stuff || bit_in != run_bit) begin
               run_bit <= bit_in;
               run_len <= 3'd1;
            end else begin
               run_len <= run_len + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/can_rx_deframer.sv
// Standard-format CAN frame receiver: bus integration, destuffing, field
// parsing, CRC-15 and form checks, one-cycle valid/error pulses.
module can_rx_deframer
   import can_pkg::*;
#(
   parameter int EOF_BITS  = 7,
   parameter int IDLE_BITS = 11,
   parameter int MAX_BYTES = 8
) (
   input  logic              can_clk,
   input  logic              reset,
   input  logic              bit_en,
   input  logic              can_lo_in,
   output logic [ID_W-1:0]   rx_id,
   output logic              rx_rtr,
   output logic [DLC_W-1:0]  rx_dlc,
   output logic [63:0]       rx_data,
   output logic              rx_valid,
   output logic              rx_error,
   output logic [2:0]        err_code,
   output logic              busy
);

   localparam logic [7:0] IDLE_MAX    = 8'(IDLE_BITS);
   localparam logic [7:0] IDLE_PRESET = 8'(IDLE_BITS - EOF_BITS - 3);
   localparam logic [6:0] EOF_LAST    = 7'(EOF_BITS - 1);
   localparam logic [3:0] MAX_B       = 4'(MAX_BYTES);

   can_state_t        state;
   logic [7:0]        idle_cnt;
   logic [6:0]        bit_cnt;
   logic [6:0]        data_bits;
   logic [ID_W-1:0]   id_sh;
   logic              rtr_sh;
   logic [DLC_W-1:0]  dlc_sh;
   logic [DLC_W-1:0]  dlc_next;
   logic [3:0]        n_bytes;
   logic [63:0]       data_sh;
   logic [5:0]        data_idx;
   logic [14:0]       crc_calc;
   logic [13:0]       crc_rx;
   logic [14:0]       crc_rx_next;
   logic              crc_bad;
   logic              sof;
   logic              dbit;
   logic              dvalid;
   logic              stuff_err;
   logic              err_hit;
   logic [2:0]        err_sel;

   assign sof         = (state == IDLE) && !can_lo_in && (idle_cnt == IDLE_MAX);
   assign crc_rx_next = {crc_rx, dbit};
   assign data_idx    = {bit_cnt[5:3], ~bit_cnt[2:0]};

   can_destuff u_destuff (
      .can_clk   (can_clk),
      .reset     (reset),
      .bit_en    (bit_en),
      .bit_in    (can_lo_in),
      .init      (sof),
      .enable    (state inside {ARB, CTRL, DATA, CRC}),
      .dbit      (dbit),
      .dvalid    (dvalid),
      .stuff_err (stuff_err)
   );

   // Byte count is decided on the last DLC bit, so it looks at the incoming bit.
   always_comb begin
      dlc_next = {dlc_sh[DLC_W-2:0], dbit};
      if (rtr_sh)                n_bytes = 4'd0;
      else if (dlc_next > MAX_B) n_bytes = MAX_B;
      else                       n_bytes = dlc_next;
   end

   always_comb begin
      err_hit = 1'b0;
      err_sel = ERR_NONE;
      if (bit_en) begin
         if (stuff_err) begin
            err_hit = 1'b1;
            err_sel = ERR_STUFF;
         end else begin
            case (state)
               CTRL: if (dvalid && bit_cnt == 7'd0 && dbit) begin
                  err_hit = 1'b1;
                  err_sel = ERR_IDE;
               end
               CRC_DEL: if (crc_bad) begin
                  err_hit = 1'b1;
                  err_sel = ERR_CRC;
               end else if (!can_lo_in) begin
                  err_hit = 1'b1;
                  err_sel = ERR_FORM;
               end
               ACK_DEL, EOF: if (!can_lo_in) begin
                  err_hit = 1'b1;
                  err_sel = ERR_FORM;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge can_clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idle_cnt  <= 8'd0;
         bit_cnt   <= 7'd0;
         data_bits <= 7'd0;
         id_sh     <= '0;
         rtr_sh    <= 1'b0;
         dlc_sh    <= '0;
         data_sh   <= 64'd0;
         crc_calc  <= 15'd0;
         crc_rx    <= 14'd0;
         crc_bad   <= 1'b0;
         rx_id     <= '0;
         rx_rtr    <= 1'b0;
         rx_dlc    <= '0;
         rx_data   <= 64'd0;
         rx_valid  <= 1'b0;
         rx_error  <= 1'b0;
         err_code  <= ERR_NONE;
         busy      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_error <= 1'b0;
         if (err_hit) begin
            rx_error <= 1'b1;
            err_code <= err_sel;
            state    <= IDLE;
            busy     <= 1'b0;
            idle_cnt <= 8'd0;
         end else if (bit_en) begin
            case (state)
               IDLE: begin
                  if (can_lo_in) begin
                     if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 8'd1;
                  end else if (sof) begin
                     state    <= ARB;
                     busy     <= 1'b1;
                     bit_cnt  <= 7'd0;
                     data_sh  <= 64'd0;
                     crc_calc <= crc15_next(15'd0, 1'b0);
                  end else begin
                     idle_cnt <= 8'd0;
                  end
               end
               ARB: if (dvalid) begin
                  crc_calc <= crc15_next(crc_calc, dbit);
                  if (bit_cnt == 7'd11) begin
                     rtr_sh  <= dbit;
                     bit_cnt <= 7'd0;
                     state   <= CTRL;
                  end else begin
                     id_sh   <= {id_sh[ID_W-2:0], dbit};
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               // IDE and r0 also pass through dlc_sh; only the last four bits stay.
               CTRL: if (dvalid) begin
                  crc_calc <= crc15_next(crc_calc, dbit);
                  dlc_sh   <= dlc_next;
                  if (bit_cnt == 7'd5) begin
                     data_bits <= {n_bytes, 3'b000};
                     bit_cnt   <= 7'd0;
                     state     <= (n_bytes == 4'd0) ? CRC : DATA;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               DATA: if (dvalid) begin
                  crc_calc          <= crc15_next(crc_calc, dbit);
                  data_sh[data_idx] <= dbit;
                  if (bit_cnt == data_bits - 7'd1) begin
                     bit_cnt <= 7'd0;
                     state   <= CRC;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               CRC: if (dvalid) begin
                  crc_rx <= crc_rx_next[13:0];
                  if (bit_cnt == 7'd14) begin
                     crc_bad <= (crc_rx_next != crc_calc);
                     state   <= CRC_DEL;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               CRC_DEL: state <= ACK;
               ACK:     state <= ACK_DEL;
               ACK_DEL: begin
                  bit_cnt <= 7'd0;
                  state   <= EOF;
               end
               EOF: begin
                  if (bit_cnt == EOF_LAST) begin
                     rx_valid <= 1'b1;
                     rx_id    <= id_sh;
                     rx_rtr   <= rtr_sh;
                     rx_dlc   <= dlc_sh;
                     rx_data  <= data_sh;
                     state    <= IDLE;
                     busy     <= 1'b0;
                     idle_cnt <= IDLE_PRESET;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_can_rx_deframer.sv
// Self-checking bench for can_rx_deframer: builds stuffed frames from field
// values, drives them at full rate and at one-in-four bit_en, checks outputs.
module tb_can_rx_deframer;

   logic        can_clk = 1'b0;
   logic        reset;
   logic        bit_en;
   logic        can_lo_in;
   logic [10:0] rx_id;
   logic        rx_rtr;
   logic [3:0]  rx_dlc;
   logic [63:0] rx_data;
   logic        rx_valid;
   logic        rx_error;
   logic [2:0]  err_code;
   logic        busy;

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   int valid_total = 0;
   int err_total   = 0;
   int err_idx_cap = -2;
   int cur_idx     = -1;
   int pass_no     = 0;
   bit sparse      = 1'b0;

   bit tx_q[$];
   int ide_idx;
   int stuff_err_idx;
   int crc_del_idx;

   logic [10:0] exp_id   = '0;
   logic        exp_rtr  = 1'b0;
   logic [3:0]  exp_dlc  = '0;
   logic [63:0] exp_data = '0;
   logic [2:0]  exp_code = '0;

   can_rx_deframer dut (
      .can_clk   (can_clk),
      .reset     (reset),
      .bit_en    (bit_en),
      .can_lo_in (can_lo_in),
      .rx_id     (rx_id),
      .rx_rtr    (rx_rtr),
      .rx_dlc    (rx_dlc),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_error  (rx_error),
      .err_code  (err_code),
      .busy      (busy)
   );

   always #5 can_clk = ~can_clk;

   // Pulse monitor; counts every cycle a pulse is seen and notes which bit caused an error.
   always @(posedge can_clk) begin
      #1;
      if (rx_valid === 1'b1) valid_total++;
      if (rx_error === 1'b1) begin
         err_total++;
         err_idx_cap = cur_idx;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("[TB] FAIL p%0d %s: observed %0h expected %0h", pass_no, tag, obs, exp);
      end
   endtask

   task automatic sendBit(input bit b, input int idx);
      if (sparse) begin
         repeat (3) begin
            @(negedge can_clk);
            bit_en    = 1'b0;
            can_lo_in = 1'($urandom_range(0, 1));
         end
      end
      @(negedge can_clk);
      bit_en    = 1'b1;
      can_lo_in = b;
      cur_idx   = idx;
   endtask

   task automatic applyStimulus(input int upto);
      for (int i = 0; i < upto; i++) sendBit(tx_q[i], i);
   endtask

   task automatic sendIdle(input int n);
      for (int i = 0; i < n; i++) sendBit(1'b1, -1);
   endtask

   function automatic int nBytes(input bit rtr, input logic [3:0] dlc);
      if (rtr) return 0;
      return (dlc > 4'd8) ? 8 : int'(dlc);
   endfunction

   // Field list -> CRC -> bit stuffing -> fixed tail, as seen on the wire.
   task automatic buildFrame(input logic [10:0] id, input bit rtr, input bit ide,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input int crc_flip, input bit no_stuff, input int eof_dom);
      bit raw[$];
      logic [14:0] crc;
      bit nxt;
      bit last;
      int run;
      int nb;
      crc = 15'd0;
      raw.push_back(1'b0);
      for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
      raw.push_back(rtr);
      raw.push_back(ide);
      raw.push_back(1'b0);
      for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
      nb = nBytes(rtr, dlc);
      for (int k = 0; k < nb; k++)
         for (int b = 7; b >= 0; b--) raw.push_back(data[8*k+b]);
      foreach (raw[j]) begin
         nxt = raw[j] ^ crc[14];
         crc = {crc[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0);
      end
      if (crc_flip >= 0) crc[crc_flip] = ~crc[crc_flip];
      for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
      tx_q.delete();
      stuff_err_idx = -1;
      run  = 0;
      last = 1'b0;
      foreach (raw[j]) begin
         if (j > 0 && run == 5) begin
            if (!no_stuff) begin
               tx_q.push_back(~last);
               last = ~last;
               run  = 1;
            end else if (raw[j] == last && stuff_err_idx < 0) begin
               stuff_err_idx = tx_q.size();
            end
         end
         if (j == 13) ide_idx = tx_q.size();
         if (j > 0 && raw[j] == last) run++;
         else begin
            last = raw[j];
            run  = 1;
         end
         tx_q.push_back(raw[j]);
      end
      crc_del_idx = tx_q.size();
      tx_q.push_back(1'b1);
      tx_q.push_back(1'b0);
      tx_q.push_back(1'b1);
      for (int e = 1; e <= 7; e++) tx_q.push_back((e == eof_dom) ? 1'b0 : 1'b1);
   endtask

   task automatic runGood(input string tag, input logic [10:0] id, input bit rtr,
                          input logic [3:0] dlc, input logic [63:0] data);
      int v0;
      int e0;
      logic [63:0] md;
      md = '0;
      for (int k = 0; k < nBytes(rtr, dlc); k++) md[8*k +: 8] = data[8*k +: 8];
      buildFrame(id, rtr, 1'b0, dlc, data, -1, 1'b0, -1);
      v0 = valid_total;
      e0 = err_total;
      applyStimulus(tx_q.size());
      sendIdle(12);
      checkOutput({tag, " valid"}, 64'(valid_total - v0), 64'd1);
      checkOutput({tag, " no_err"}, 64'(err_total - e0), 64'd0);
      checkOutput({tag, " id"}, 64'(rx_id), 64'(id));
      checkOutput({tag, " rtr"}, 64'(rx_rtr), 64'(rtr));
      checkOutput({tag, " dlc"}, 64'(rx_dlc), 64'(dlc));
      checkOutput({tag, " data"}, rx_data, md);
      checkOutput({tag, " code"}, 64'(err_code), 64'(exp_code));
      checkOutput({tag, " busy"}, 64'(busy), 64'd0);
      exp_id   = id;
      exp_rtr  = rtr;
      exp_dlc  = dlc;
      exp_data = md;
   endtask

   task automatic runError(input string tag, input logic [2:0] code, input int idx, input int idle_after);
      int v0;
      int e0;
      v0 = valid_total;
      e0 = err_total;
      applyStimulus(tx_q.size());
      sendIdle(idle_after);
      checkOutput({tag, " err"}, 64'(err_total - e0), 64'd1);
      checkOutput({tag, " no_valid"}, 64'(valid_total - v0), 64'd0);
      checkOutput({tag, " code"}, 64'(err_code), 64'(code));
      checkOutput({tag, " where"}, 64'(err_idx_cap), 64'(idx));
      checkOutput({tag, " id_kept"}, 64'(rx_id), 64'(exp_id));
      checkOutput({tag, " data_kept"}, rx_data, exp_data);
      exp_code = code;
   endtask

   initial begin
      int v0;
      int e0;
      logic [63:0] rnd;
      reset     = 1'b1;
      bit_en    = 1'b0;
      can_lo_in = 1'b1;
      repeat (3) @(negedge can_clk);
      checkOutput("rst id", 64'(rx_id), 64'd0);
      checkOutput("rst rtr", 64'(rx_rtr), 64'd0);
      checkOutput("rst dlc", 64'(rx_dlc), 64'd0);
      checkOutput("rst data", rx_data, 64'd0);
      checkOutput("rst valid", 64'(rx_valid), 64'd0);
      checkOutput("rst error", 64'(rx_error), 64'd0);
      checkOutput("rst code", 64'(err_code), 64'd0);
      checkOutput("rst busy", 64'(busy), 64'd0);
      reset = 1'b0;

      for (int p = 0; p < 2; p++) begin
         pass_no = p;
         sparse  = (p == 1);
         $display("[TB] pass %0d, sparse bit_en=%0d", p, sparse);
         sendIdle(11);

         runGood("basic", 11'h123, 1'b0, 4'd1, 64'h89);

         buildFrame(11'h003, 1'b0, 1'b0, 4'd1, 64'h89, -1, 1'b1, -1);
         runError("stuff", 3'd1, stuff_err_idx, 12);

         buildFrame(11'h123, 1'b0, 1'b0, 4'd1, 64'h89, 3, 1'b0, -1);
         runError("crc", 3'd3, crc_del_idx, 12);

         runGood("dlc15", 11'h555, 1'b0, 4'hF, 64'h0807060504030201);
         runGood("rtr", 11'h2A7, 1'b1, 4'hF, 64'h0807060504030201);

         buildFrame(11'h123, 1'b0, 1'b1, 4'd1, 64'h89, -1, 1'b0, -1);
         runError("ide", 3'd4, ide_idx, 12);

         buildFrame(11'h123, 1'b0, 1'b0, 4'd1, 64'h89, -1, 1'b0, 4);
         runError("eof", 3'd2, crc_del_idx + 6, 5);

         buildFrame(11'h123, 1'b0, 1'b0, 4'd1, 64'h89, -1, 1'b0, -1);
         v0 = valid_total;
         e0 = err_total;
         applyStimulus(tx_q.size());
         sendIdle(12);
         checkOutput("early_sof valid", 64'(valid_total - v0), 64'd0);
         checkOutput("early_sof err", 64'(err_total - e0), 64'd0);
         checkOutput("early_sof busy", 64'(busy), 64'd0);

         for (int r = 0; r < 4; r++) begin
            rnd = {$urandom, $urandom};
            runGood($sformatf("rand%0d", r), 11'($urandom_range(0, 2047)),
                    ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), rnd);
         end

         rnd = {$urandom, $urandom};
         buildFrame(11'h4C1, 1'b0, 1'b0, 4'd8, rnd, -1, 1'b0, -1);
         v0 = valid_total;
         e0 = err_total;
         applyStimulus(ide_idx + 24);
         checkOutput("midrst busy_before", 64'(busy), 64'd1);
         @(negedge can_clk);
         bit_en = 1'b0;
         reset  = 1'b1;
         repeat (2) @(negedge can_clk);
         checkOutput("midrst id", 64'(rx_id), 64'd0);
         checkOutput("midrst dlc", 64'(rx_dlc), 64'd0);
         checkOutput("midrst data", rx_data, 64'd0);
         checkOutput("midrst code", 64'(err_code), 64'd0);
         checkOutput("midrst busy", 64'(busy), 64'd0);
         checkOutput("midrst valid", 64'(rx_valid), 64'd0);
         checkOutput("midrst error", 64'(rx_error), 64'd0);
         reset = 1'b0;
         checkOutput("midrst no_valid", 64'(valid_total - v0), 64'd0);
         checkOutput("midrst no_err", 64'(err_total - e0), 64'd0);
         exp_id   = '0;
         exp_rtr  = 1'b0;
         exp_dlc  = '0;
         exp_data = '0;
         exp_code = '0;
         sendIdle(11);
         runGood("after_rst", 11'h123, 1'b0, 4'd1, 64'h89);

         // Leave the DUT cleanly reset so both passes start from the same state.
         @(negedge can_clk);
         bit_en = 1'b0;
         reset  = 1'b1;
         @(negedge can_clk);
         reset    = 1'b0;
         exp_id   = '0;
         exp_rtr  = 1'b0;
         exp_dlc  = '0;
         exp_data = '0;
         exp_code = '0;
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
